// File: rtl/clk_div_calc.sv
// Converts a requested output frequency into a rounded, clamped clock divisor.
// The quotient is produced by a 32-step restoring divider, one bit per clock.
module clk_div_calc #(
   parameter logic [31:0] CLK_FREQ_HZ = 32'd100_000_000,
   parameter logic [31:0] DIV_MIN     = 32'd1,
   parameter logic [31:0] DIV_MAX     = 32'hFFFF_FFFF,
   parameter logic [31:0] DIV_INIT    = 32'd2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] freq_hz,
   input  logic        freq_valid,
   output logic        freq_ready,
   output logic [31:0] div,
   output logic        div_valid,
   output logic        range_err,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] d_q, d_d;
   logic [31:0] n_q, n_d;
   logic [31:0] r_q, r_d;
   logic [31:0] q_q, q_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] div_q, div_d;
   logic        vld_q, vld_d;
   logic        err_q, err_d;

   logic [32:0] r_shift;
   logic        r_ge;
   logic        q_under, q_over;

   // Clamp comparisons collapse to constants when the bound is the full range.
   generate
      if (DIV_MIN == 32'd0) begin : g_no_min
         assign q_under = 1'b0;
      end else begin : g_min
         assign q_under = q_q < DIV_MIN;
      end
      if (DIV_MAX == 32'hFFFF_FFFF) begin : g_no_max
         assign q_over = 1'b0;
      end else begin : g_max
         assign q_over = q_q > DIV_MAX;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      n_d     = n_q;
      r_d     = r_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      vld_d   = 1'b0;
      err_d   = err_q;
      // N is consumed MSB first by shifting it left each iteration.
      r_shift = {r_q, n_q[31]};
      r_ge    = r_shift >= {1'b0, d_q};
      case (state_q)
         IDLE: begin
            if (freq_valid) begin
               d_d     = freq_hz;
               n_d     = CLK_FREQ_HZ + (freq_hz >> 1);
               r_d     = '0;
               q_d     = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            // Remainder after a subtract is below D, so 32 bits always suffice.
            r_d   = r_ge ? (r_shift[31:0] - d_q) : r_shift[31:0];
            q_d   = {q_q[30:0], r_ge};
            n_d   = {n_q[30:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = DONE;
         end
         DONE: begin
            vld_d   = 1'b1;
            state_d = IDLE;
            if (d_q == 32'd0) begin
               div_d = DIV_MAX;
               err_d = 1'b1;
            end else if (q_under) begin
               div_d = DIV_MIN;
               err_d = 1'b1;
            end else if (q_over) begin
               div_d = DIV_MAX;
               err_d = 1'b1;
            end else begin
               div_d = q_q;
               err_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         d_q     <= '0;
         n_q     <= '0;
         r_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         div_q   <= DIV_INIT;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         n_q     <= n_d;
         r_q     <= r_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   assign freq_ready = (state_q == IDLE);
   assign busy       = ~freq_ready;
   assign div        = div_q;
   assign div_valid  = vld_q;
   assign range_err  = err_q;

endmodule

// File: tb/tb_clk_div_calc.sv
// Directed bench for clk_div_calc: vector table plus back-to-back and reset-abort sequences.
module tb_clk_div_calc;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic [31:0] freq_hz = '0;
   logic        freq_valid = 1'b0;
   logic        freq_ready;
   logic [31:0] div;
   logic        div_valid;
   logic        range_err;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] freq;
      logic [31:0] div;
      logic        err;
      string       name;
   } vec_t;

   vec_t vecs[7];

   clk_div_calc dut (
      .clk        (clk),
      .rstn       (rstn),
      .freq_hz    (freq_hz),
      .freq_valid (freq_valid),
      .freq_ready (freq_ready),
      .div        (div),
      .div_valid  (div_valid),
      .range_err  (range_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Issue one request and check handshake timing and the result.
   task automatic do_req(input logic [31:0] f, input logic [31:0] ediv, input logic eerr,
                         input string name);
      int k;
      bit seen;
      @(negedge clk);
      check({name, " ready_before"}, {31'd0, freq_ready}, 32'd1);
      freq_hz    = f;
      freq_valid = 1'b1;
      @(posedge clk);
      #1;
      freq_valid = 1'b0;
      freq_hz    = 32'hDEAD_BEEF;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (k == 2) check({name, " busy"}, {30'd0, busy, freq_ready}, 32'd2);
         if (div_valid) seen = 1'b1;
      end
      check({name, " latency"}, k, 32'd34);
      check({name, " div"}, div, ediv);
      check({name, " range_err"}, {31'd0, range_err}, {31'd0, eerr});
      check({name, " ready_at_valid"}, {31'd0, freq_ready}, 32'd1);
      @(negedge clk);
      check({name, " valid_one_cycle"}, {31'd0, div_valid}, 32'd0);
      check({name, " div_held"}, div, ediv);
   endtask

   initial begin
      logic [31:0] seq[3];
      logic [31:0] seq_exp[3];
      int idx, c, last, spurious;

      vecs[0] = '{32'd10_000_000,  32'd10,          1'b0, "exact_10M"};
      vecs[1] = '{32'd3_000_000,   32'd33,          1'b0, "round_3M"};
      vecs[2] = '{32'd40_000_000,  32'd3,           1'b0, "half_40M"};
      vecs[3] = '{32'd7_000_000,   32'd14,          1'b0, "round_7M"};
      vecs[4] = '{32'd0,           32'hFFFF_FFFF,   1'b1, "zero_freq"};
      vecs[5] = '{32'd300_000_000, 32'd1,           1'b1, "clamp_min"};
      vecs[6] = '{32'd50_000_000,  32'd2,           1'b0, "after_err"};

      // Reset state
      #2 rstn = 1'b0;
      #3;
      check("rst div", div, 32'd2);
      check("rst div_valid", {31'd0, div_valid}, 32'd0);
      check("rst freq_ready", {31'd0, freq_ready}, 32'd1);
      check("rst range_err", {31'd0, range_err}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (5) @(negedge clk);
      check("idle div", div, 32'd2);
      check("idle flags", {28'd0, div_valid, freq_ready, range_err, busy}, 32'b0100);

      foreach (vecs[i]) do_req(vecs[i].freq, vecs[i].div, vecs[i].err, vecs[i].name);

      // Back-to-back with freq_valid held; freq_hz scrambled while busy.
      seq     = '{32'd100_000_000, 32'd25_000_000, 32'd11_100_000};
      seq_exp = '{32'd1, 32'd4, 32'd9};
      @(negedge clk);
      freq_hz    = seq[0];
      freq_valid = 1'b1;
      idx = 0; c = 0; last = 0;
      while (idx < 3 && c < 200) begin
         @(negedge clk);
         c++;
         if (div_valid) begin
            check($sformatf("b2b div[%0d]", idx), div, seq_exp[idx]);
            check($sformatf("b2b err[%0d]", idx), {31'd0, range_err}, 32'd0);
            if (idx > 0) check($sformatf("b2b gap[%0d]", idx), c - last, 32'd34);
            last = c;
            idx++;
            if (idx < 3) freq_hz = seq[idx];
            else freq_valid = 1'b0;
         end else if (busy) begin
            freq_hz = $urandom;
         end
      end
      freq_valid = 1'b0;
      check("b2b results", idx, 32'd3);

      // Reset mid-computation aborts the request.
      @(negedge clk);
      freq_hz    = 32'd20_000_000;
      freq_valid = 1'b1;
      @(posedge clk);
      #1 freq_valid = 1'b0;
      repeat (15) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      check("abort div", div, 32'd2);
      check("abort div_valid", {31'd0, div_valid}, 32'd0);
      check("abort freq_ready", {31'd0, freq_ready}, 32'd1);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      spurious = 0;
      repeat (40) begin
         @(negedge clk);
         if (div_valid) spurious++;
      end
      check("abort no_valid", spurious, 32'd0);
      check("abort div_after", div, 32'd2);
      do_req(32'd20_000_000, 32'd5, 1'b0, "after_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_div_calc.md
Name: clk_div_calc

Overview:
- Upstream configuration stage for the clock divider block.
- Converts a requested output frequency in Hz into the integer divisor `div` and issues it with a one-cycle `div_valid` strobe, which is the divisor-load interface of the divider.
- Rounds to nearest, clamps to a legal divisor range and flags out-of-range requests.
- Uses an iterative 32-step restoring divider, one bit per clock, to avoid a combinational 32-bit divide.

Parameters:
- CLK_FREQ_HZ, 100_000_000: frequency of `clk` in Hz. Legal range 1 .. 2^31-1.
- DIV_MIN, 1: smallest divisor ever emitted.
- DIV_MAX, 32'hFFFF_FFFF: largest divisor ever emitted. Must satisfy DIV_MIN <= DIV_MAX.
- DIV_INIT, 2: value of `div` after reset.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- freq_hz  input  32  requested output frequency in Hz; sampled on the accept edge.
- freq_valid  input  1  request valid; upstream holds it until accepted.
- freq_ready  output  1  block idle, request can be accepted.
- div  output  32  divisor to the clock divider; holds its value between updates.
- div_valid  output  1  one-cycle strobe; `div` is new this cycle.
- range_err  output  1  qualifies the current `div`: the last result was clamped or freq_hz was 0.
- busy  output  1  computation in progress; equals ~freq_ready.

Behaviour:
- Reset (async assert, sync-safe deassert by the integrator): state IDLE, freq_ready=1, busy=0, div=DIV_INIT, div_valid=0, range_err=0, all datapath registers cleared.
- Reset asserted mid-computation aborts it; no div_valid is produced for the aborted request.
- Accept: on a rising edge with freq_valid && freq_ready (edge T):
  - latch D=freq_hz;
  - latch N=CLK_FREQ_HZ + (freq_hz>>1), 32 bits, cannot overflow given the CLK_FREQ_HZ limit;
  - clear remainder R (33 bits) and quotient Q (32 bits);
  - state goes to CALC.
- States:
  - IDLE: freq_ready=1. Goes to CALC on accept.
  - CALC: 32 iterations on edges T+1..T+32, iteration counter 0..31.
    - Each iteration: R' = {R, N[31-k]}. If R' >= D then R = R'-D and Q bit = 1, else R = R' and Q bit = 0.
    - After the 32nd iteration, go to DONE.
  - DONE: at edge T+33, apply clamping, register div, range_err and div_valid=1, then go to IDLE.
- Latency and handshake:
  - Accept to div_valid high is 33 clocks. div_valid is high for exactly the one cycle after edge T+33.
  - freq_ready is low from T+1 through T+33 and rises in the same cycle div_valid is high, so a new request may be accepted on the edge that ends the div_valid cycle.
  - Throughput: one result per 34 cycles.
  - freq_valid while busy is ignored; no queueing. Upstream must hold freq_hz stable only until accept.
- Result rule: Q = floor((CLK_FREQ_HZ + floor(freq_hz/2)) / freq_hz), i.e. round-half-up.
  - freq_hz==0: the divide is skipped logically. div=DIV_MAX, range_err=1, same 33-cycle latency (CALC still runs; the result is overridden).
  - Q < DIV_MIN: div=DIV_MIN, range_err=1.
  - Q > DIV_MAX: div=DIV_MAX, range_err=1.
  - Otherwise div=Q, range_err=0.
- range_err updates only with div_valid and holds until the next result.
- Simultaneous reset and accept: reset wins.

Test Plan:
- Reset state: assert rstn=0 -> div=2, div_valid=0, freq_ready=1, range_err=0. Release rstn and apply no request -> outputs stay unchanged.
- Exact divide: freq_hz=10_000_000 accepted at edge T -> freq_ready=0 from T+1, div_valid high one cycle after T+33, div=10, range_err=0.
- Rounding:
  - 3_000_000 -> div=33;
  - 40_000_000 (2.5 exact) -> div=3;
  - 7_000_000 -> div=14.
- Clamp and error:
  - freq_hz=0 -> div=32'hFFFF_FFFF, range_err=1;
  - 300_000_000 (Q=0) -> div=1, range_err=1;
  - next request 50_000_000 -> div=2, range_err=0.
- Back-to-back: hold freq_valid high with sequence 100e6, 25e6, 11.1e6 -> results div=1, 4, 9; consecutive div_valid pulses exactly 34 cycles apart; mid-busy changes to freq_hz are ignored.
- Reset mid-operation: accept 20_000_000, assert rstn=0 at T+15 -> no div_valid, div=2. Release reset and request 20_000_000 -> div=5 after 33 cycles.
